// File: rtl/serial_subtractor.sv
// serial_subtractor: unsigned a - b over WIDTH bits, DIGIT bits per clock, borrow ripples through a register.
// Latency: start at edge t -> busy t..t+N, results and done pulse at edge t+N (N = WIDTH/DIGIT), N+2 cycles per op.
// Backpressure: none; start is only sampled in IDLE and ignored while RUN or DONE.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start, a, b         request and operands, sampled together in IDLE
//   busy, done          busy while digits are being processed; done is a one-cycle pulse
//   diff, borrow_out,   result, final borrow (a < b) and diff == 0; all hold until
//   zero                the next completion
//
// Build option: define SERIAL_SUB_SAT_EN for saturating subtraction (underflow gives diff = 0).
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] fin_d;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic [DIGIT:0]   dig;
  logic             last_dig;

  // One digit of the borrow chain: the top bit of the DIGIT+1 wide result is the borrow out.
  assign dig = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};

  // Result digits enter at the MSB end, so after N shifts digit 0 sits at the LSB.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_nx = dig[DIGIT-1:0];
    end else begin : g_multi
      assign res_nx = {dig[DIGIT-1:0], res_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SERIAL_SUB_SAT_EN
  assign fin_d = dig[DIGIT] ? '0 : res_nx;
`else
  assign fin_d = res_nx;
`endif

  assign last_dig = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_sh   <= a;
        b_sh   <= b;
        res_sh <= '0;
        cnt    <= '0;
        brw    <= 1'b0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> DIGIT;
        b_sh   <= b_sh >> DIGIT;
        res_sh <= res_nx;
        brw    <= dig[DIGIT];
        cnt    <= cnt + CW'(1);
      end
      // Published results only move on the final digit so they stay stable between operations.
      if (last_dig) begin
        diff       <= fin_d;
        borrow_out <= dig[DIGIT];
        zero       <= (fin_d == '0);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start_in [3];
  logic [15:0] a_in     [3];
  logic [15:0] b_in     [3];
  logic        busy_o   [3];
  logic        done_o   [3];
  logic        bo_o     [3];
  logic        zero_o   [3];
  logic [15:0] diff_o   [3];
  logic [7:0]  d0;
  logic [15:0] d1;
  logic [7:0]  d2;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance
  int          cyc;
  int          acc_t  [3];
  bit          have   [3];
  logic [15:0] pend_d [3];
  logic        pend_b [3];
  logic        pend_z [3];
  logic [15:0] exp_d  [3];
  logic        exp_b  [3];
  logic        exp_z  [3];

  // Instance 0: 8/1 (N=8), instance 1: 16/4 (N=4), instance 2: 8/8 (N=1)
  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_in[0]), .a(a_in[0][7:0]), .b(b_in[0][7:0]),
    .busy(busy_o[0]), .done(done_o[0]), .diff(d0), .borrow_out(bo_o[0]), .zero(zero_o[0]));
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_in[1]), .a(a_in[1]), .b(b_in[1]),
    .busy(busy_o[1]), .done(done_o[1]), .diff(d1), .borrow_out(bo_o[1]), .zero(zero_o[1]));
  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_in[2]), .a(a_in[2][7:0]), .b(b_in[2][7:0]),
    .busy(busy_o[2]), .done(done_o[2]), .diff(d2), .borrow_out(bo_o[2]), .zero(zero_o[2]));

  assign diff_o[0] = {8'h00, d0};
  assign diff_o[1] = d1;
  assign diff_o[2] = {8'h00, d2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int n_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
  endfunction

  function automatic logic [15:0] mask_of(input int k);
    return (k == 1) ? 16'hFFFF : 16'h00FF;
  endfunction

  // Plain arithmetic: what a finished subtraction must report
  task automatic model_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] d, output logic bo, output logic z);
    logic [15:0] m;
    logic [15:0] am;
    logic [15:0] bm;
    m  = mask_of(k);
    am = a & m;
    bm = b & m;
    bo = (am < bm);
    d  = (am - bm) & m;
`ifdef SERIAL_SUB_SAT_EN
    if (bo) d = 16'h0000;
`endif
    z  = (d == 16'h0000);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      have[k]   = 1'b0;
      acc_t[k]  = 0;
      pend_d[k] = '0; pend_b[k] = 1'b0; pend_z[k] = 1'b0;
      exp_d[k]  = '0; exp_b[k]  = 1'b0; exp_z[k]  = 1'b0;
    end
  endtask

  task automatic wait_done(input int k, input string name);
    int n;
    n = 0;
    while (!done_o[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, {15'd0, done_o[k]}, 16'd1);
  endtask

  task automatic op(input int k, input logic [15:0] a, input logic [15:0] b, input string name);
    @(posedge clk); #2;
    a_in[k] = a; b_in[k] = b; start_in[k] = 1'b1;
    @(posedge clk); #2;
    start_in[k] = 1'b0;
    a_in[k] = 16'($urandom); b_in[k] = 16'($urandom);
    wait_done(k, name);
  endtask

  task automatic lit(input int k, input string name, input logic [15:0] d, input logic bo, input logic z);
    chk({name, "_diff"}, diff_o[k], d);
    chk({name, "_borrow"}, {15'd0, bo_o[k]}, {15'd0, bo});
    chk({name, "_zero"}, {15'd0, zero_o[k]}, {15'd0, z});
  endtask

  initial begin
    int dcount;
    rst_n = 1'b0;
    cyc   = 0;
    for (int k = 0; k < 3; k++) begin
      start_in[k] = 1'b0; a_in[k] = '0; b_in[k] = '0;
    end
    model_clear();

    fork
      // Model: accept when idle, publish N edges later, idle again N+2 edges after accept
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          model_clear();
        end else begin
          cyc++;
          for (int k = 0; k < 3; k++) begin
            if (have[k] && cyc == acc_t[k] + n_of(k)) begin
              exp_d[k] = pend_d[k]; exp_b[k] = pend_b[k]; exp_z[k] = pend_z[k];
            end
            if (start_in[k] && (!have[k] || cyc >= acc_t[k] + n_of(k) + 2)) begin
              have[k]  = 1'b1;
              acc_t[k] = cyc;
              model_op(k, a_in[k], b_in[k], pend_d[k], pend_b[k], pend_z[k]);
            end
          end
        end
      end
      // Compare every cycle, mid-period
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          logic eb;
          logic ed;
          eb = have[k] && cyc >= acc_t[k] && cyc < acc_t[k] + n_of(k);
          ed = have[k] && cyc == acc_t[k] + n_of(k);
          chk($sformatf("busy%0d", k), {15'd0, busy_o[k]}, {15'd0, eb});
          chk($sformatf("done%0d", k), {15'd0, done_o[k]}, {15'd0, ed});
          chk($sformatf("diff%0d", k), diff_o[k], exp_d[k]);
          chk($sformatf("borrow%0d", k), {15'd0, bo_o[k]}, {15'd0, exp_b[k]});
          chk($sformatf("zero%0d", k), {15'd0, zero_o[k]}, {15'd0, exp_z[k]});
        end
      end
    join_none

    // Reset state
    @(posedge clk); @(posedge clk); #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy%0d", k), {15'd0, busy_o[k]}, 16'd0);
      chk($sformatf("rst_done%0d", k), {15'd0, done_o[k]}, 16'd0);
      lit(k, $sformatf("rst%0d", k), 16'h0000, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    // Directed cases with hand-computed results
    op(0, 16'h005A, 16'h0021, "a5a_b21");
    lit(0, "a5a_b21", 16'h0039, 1'b0, 1'b0);
    op(0, 16'h0000, 16'h0001, "under");
`ifdef SERIAL_SUB_SAT_EN
    lit(0, "under", 16'h0000, 1'b1, 1'b1);
`else
    lit(0, "under", 16'h00FF, 1'b1, 1'b0);
`endif
    op(0, 16'h0077, 16'h0077, "equal");
    lit(0, "equal", 16'h0000, 1'b0, 1'b1);
    op(0, 16'h0010, 16'h0001, "zero_drop");
    lit(0, "zero_drop", 16'h000F, 1'b0, 1'b0);
    op(1, 16'h1234, 16'h0F0F, "w16");
    lit(1, "w16", 16'h0325, 1'b0, 1'b0);
    op(2, 16'h00F0, 16'h000F, "n1");
    lit(2, "n1", 16'h00E1, 1'b0, 1'b0);

    // start held high on the 16/4 instance: one op per 6 cycles
    @(posedge clk); #2;
    start_in[1] = 1'b1; a_in[1] = 16'($urandom); b_in[1] = 16'($urandom);
    dcount = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done_o[1]) dcount++;
      a_in[1] = 16'($urandom); b_in[1] = 16'($urandom);
    end
    start_in[1] = 1'b0;
    chk("held_start_dones", 16'(dcount), 16'd4);

    // A second start while running is ignored
    @(posedge clk); #2;
    a_in[0] = 16'h00C3; b_in[0] = 16'h0042; start_in[0] = 1'b1;
    @(posedge clk); #2;
    start_in[0] = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    a_in[0] = 16'h0001; b_in[0] = 16'h00FF; start_in[0] = 1'b1;
    @(posedge clk); #2;
    start_in[0] = 1'b0;
    wait_done(0, "ignore");
    lit(0, "ignore", 16'h0081, 1'b0, 1'b0);

    // Reset during RUN aborts with everything cleared and no done
    @(posedge clk); #2;
    a_in[0] = 16'h0080; b_in[0] = 16'h0001; start_in[0] = 1'b1;
    @(posedge clk); #2;
    start_in[0] = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {15'd0, busy_o[0]}, 16'd0);
    chk("abort_done", {15'd0, done_o[0]}, 16'd0);
    lit(0, "abort", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_o[0]) dcount++;
    end
    chk("abort_no_done", 16'(dcount), 16'd0);
    op(0, 16'h0005, 16'h0003, "post_rst");
    lit(0, "post_rst", 16'h0002, 1'b0, 1'b0);

    // Randomized traffic: random instance, operands, start hold length and gaps
    for (int i = 0; i < 60; i++) begin
      int k;
      int h;
      int g;
      k = $urandom_range(0, 2);
      h = $urandom_range(1, 3);
      g = $urandom_range(0, 12);
      @(posedge clk); #2;
      start_in[k] = 1'b1;
      for (int j = 0; j < h; j++) begin
        a_in[k] = (i % 7 == 0) ? b_in[k] : 16'($urandom);
        if (i % 5 == 0) b_in[k] = a_in[k] + 16'd1;
        else b_in[k] = 16'($urandom);
        @(posedge clk); #2;
      end
      start_in[k] = 1'b0;
      for (int j = 0; j < g; j++) @(posedge clk);
    end
    for (int j = 0; j < 14; j++) @(posedge clk);
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle unsigned subtractor that computes `a - b` over `WIDTH` bits, `DIGIT` bits per clock. A registered borrow carries between digits, the same borrow chain a half/full-subtractor ripple forms, but folded in time. It sits beside the combinational subtractor cells as the area-lean option for wide operands. A start/busy/done handshake hands it to a controlling FSM.

## Interface
- `WIDTH`, default 8: operand and result width in bits; ≥ 2.
- `DIGIT`, default 1: bits processed per cycle; must divide `WIDTH`. `N = WIDTH/DIGIT` is the digit count.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; sampled with `start`.
- `b`  in  WIDTH  subtrahend; sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; results valid.
- `diff`  out  WIDTH  result; holds until next completion.
- `borrow_out`  out  1  final borrow (a < b); holds with `diff`.
- `zero`  out  1  `diff == 0`; holds with `diff`.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- **IDLE:** `start=1` latches `a` and `b` into shift registers, clears the internal borrow and the digit counter, and moves to RUN.
  - `start=0` stays in IDLE.
- **RUN:** each edge processes the low `DIGIT` bits of both shift registers.
  - Digit math: `{bo, d} = a_dig - b_dig - borrow`, computed `DIGIT+1` bits wide; `bo` becomes the new borrow.
  - `d` shifts into the result register from the MSB side. Both operand registers shift right by `DIGIT`.
  - The counter increments. On the edge processing digit `N-1`, move to DONE.
  - On that same edge, update `diff`, `borrow_out` (final `bo`) and `zero`.
- **DONE:** `done=1` for exactly one cycle, then unconditionally to IDLE.
- `start` in RUN or DONE is ignored; operands are not re-sampled.
- `a` and `b` may change freely after the sampling edge.
- Result is `(a - b) mod 2^WIDTH`; `borrow_out=1` iff `a < b` unsigned.
- `diff`, `borrow_out` and `zero` change only on the final RUN edge. They are stable from `done` until the next completion.
- Reset mid-operation aborts: state IDLE, all registers and outputs 0, no `done`.

## Timing
- Reset values: `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `zero=0`; state IDLE; counter and borrow 0.
- `start` sampled at edge t; `busy=1` from t to t+N.
- Results registered at edge t+N; `done=1` from t+N to t+N+1.
- Next `start` can be accepted at edge t+N+2 (back in IDLE). Throughput is one operation per N+2 cycles.
- `DIGIT=WIDTH` gives N=1: `done` one cycle after the single RUN edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SERIAL_SUB_SAT_EN` defined:
  - On completion with final borrow 1, `diff` is forced to 0 and `zero=1`; `borrow_out` is still 1.
  - Gives saturating unsigned subtraction.
- Not defined: `diff` is the modulo-2^WIDTH wrap result.
- Latency and handshake are identical in both builds.

## Test plan
- WIDTH=8, DIGIT=1:
  - `a=0x5A`, `b=0x21`, start pulse → `busy` for 8 cycles.
  - Expect `done` at edge t+8 with `diff=0x39`, `borrow_out=0`, `zero=0`.
- WIDTH=8, DIGIT=1, underflow:
  - `a=0x00`, `b=0x01`.
  - Without macro: `diff=0xFF`, `borrow_out=1`.
  - With `SERIAL_SUB_SAT_EN`: `diff=0x00`, `borrow_out=1`, `zero=1`.
- WIDTH=8, equal operands:
  - `a=b=0x77` → `diff=0x00`, `zero=1`, `borrow_out=0`.
  - `zero` must deassert on a following `0x10-0x01` → `diff=0x0F`.
- WIDTH=16, DIGIT=4:
  - `a=0x1234`, `b=0x0F0F`.
  - Expect `done` 4 cycles after start, `diff=0x0325`, `borrow_out=0`.
  - `start` held high continuously → one operation per 6 cycles, no extra `done`.
- Mid-operation hazards:
  - `start` with new operands during RUN is ignored; the original result is reported.
  - `rst_n` low at RUN cycle 3 → all outputs 0 immediately, no `done`.
  - After reset release, a fresh `0x05-0x03` gives `diff=0x02`.
